// File: rtl/md_unit_if.sv
// Multiply/divide unit request/response bundle: operands and opcode in,
// busy flag, HI/LO registers and the read port out.
interface md_unit_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mdop;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdout;

    modport master (output a, b, mdop, start, input busy, hi, lo, mdout);
    modport slave  (input a, b, mdop, start, output busy, hi, lo, mdout);
endinterface

// File: rtl/md_unit.sv
// HI/LO multiply/divide unit: the result is computed at the accepting edge and
// held in pending registers, then exposed on hi/lo after a fixed busy window.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    md_unit_if.slave   md
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] phi_q, phi_d, plo_q, plo_d;
    logic        pwr_q, pwr_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, qmag, rmag, quot_s, rem_s, quot_u, rem_u;
    logic        b_zero;

    assign prod_s = {{32{md.a[31]}}, md.a} * {{32{md.b[31]}}, md.b};
    assign prod_u = {32'd0, md.a} * {32'd0, md.b};

    // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow trap and
    // naturally yields 0x80000000 for that case.
    assign b_zero = (md.b == 32'd0);
    assign mag_a  = md.a[31] ? -md.a : md.a;
    assign mag_b  = md.b[31] ? -md.b : md.b;
    assign qmag   = b_zero ? 32'd0 : mag_a / mag_b;
    assign rmag   = b_zero ? 32'd0 : mag_a % mag_b;
    assign quot_s = (md.a[31] ^ md.b[31]) ? -qmag : qmag;
    assign rem_s  = md.a[31] ? -rmag : rmag;
    assign quot_u = b_zero ? 32'd0 : md.a / md.b;
    assign rem_u  = b_zero ? 32'd0 : md.a % md.b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        pwr_d   = pwr_q;
        case (state_q)
            S_IDLE: begin
                if (md.start) begin
                    case (md.mdop)
                        OP_MULT: begin
                            {phi_d, plo_d} = prod_s;
                            pwr_d   = 1'b1;
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MULTU: begin
                            {phi_d, plo_d} = prod_u;
                            pwr_d   = 1'b1;
                            cnt_d   = 4'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            // Divide by zero still occupies the unit but never commits.
                            if (!b_zero) begin
                                phi_d = (md.mdop == OP_DIV) ? rem_s  : rem_u;
                                plo_d = (md.mdop == OP_DIV) ? quot_s : quot_u;
                            end
                            pwr_d   = !b_zero;
                            cnt_d   = 4'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                        OP_MTHI: hi_d = md.a;
                        OP_MTLO: lo_d = md.a;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    if (pwr_q) begin
                        hi_d = phi_q;
                        lo_d = plo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            pwr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
            pwr_q   <= pwr_d;
        end
    end

    assign md.busy  = busy_q;
    assign md.hi    = hi_q;
    assign md.lo    = lo_q;
    assign md.mdout = (md.mdop == OP_MFHI) ? hi_q :
                      (md.mdop == OP_MFLO) ? lo_q : 32'd0;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table through a scoreboard, plus
// hand sequences for busy-time reads/writes, back-to-back issue and reset abort.
module tb_md_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if bus();
    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .md(bus));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cyc;
    } vec_t;
    typedef struct {
        logic [31:0] hi, lo;
    } res_t;

    res_t sb_q[$];
    vec_t vecs[15];
    int   errors = 0;
    int   checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name);
        res_t r;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        r = sb_q.pop_front();
        check32({name, "_hi"}, bus.hi, r.hi);
        check32({name, "_lo"}, bus.lo, r.lo);
        bus.mdop = 4'd7; #1 check32({name, "_mfhi"}, bus.mdout, r.hi);
        bus.mdop = 4'd8; #1 check32({name, "_mflo"}, bus.mdout, r.lo);
        bus.mdop = 4'd0; #1 check32({name, "_mdnone"}, bus.mdout, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        string nm;
        nm = $sformatf("vec%0d", idx);
        @(negedge clk);
        bus.mdop = v.op; bus.a = v.a; bus.b = v.b; bus.start = 1'b1;
        sb_q.push_back('{v.hi, v.lo});
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0; bus.a = $urandom; bus.b = $urandom;
        wait_idle(n);
        check32({nm, "_busycyc"}, 32'(n), 32'(v.cyc));
        check_result(nm);
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'd5,  32'h12345678, 32'h0,        32'h12345678, 32'h00000000, 0};
        vecs[1]  = '{4'd6,  32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0};
        vecs[2]  = '{4'd1,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[3]  = '{4'd2,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[4]  = '{4'd3,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5]  = '{4'd4,  32'h7,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[6]  = '{4'd3,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[7]  = '{4'd4,  32'h64,       32'h7,        32'h00000002, 32'h0000000E, 10};
        vecs[8]  = '{4'd3,  32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[9]  = '{4'd1,  32'h7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 5};
        vecs[10] = '{4'd2,  32'h10000,    32'h10000,    32'h00000001, 32'h00000000, 5};
        vecs[11] = '{4'd3,  32'h5,        32'h0,        32'h00000001, 32'h00000000, 10};
        vecs[12] = '{4'd9,  32'hAAAAAAAA, 32'h1,        32'h00000001, 32'h00000000, 0};
        vecs[13] = '{4'd0,  32'hBBBBBBBB, 32'h1,        32'h00000001, 32'h00000000, 0};
        vecs[14] = '{4'd7,  32'hCCCCCCCC, 32'h1,        32'h00000001, 32'h00000000, 0};

        // Reset overrides a simultaneous MTHI.
        reset = 1'b1; bus.start = 1'b1; bus.mdop = 4'd5; bus.a = 32'hFFFFFFFF; bus.b = 32'h0;
        repeat (3) @(negedge clk);
        check32("rst_busy", 32'(bus.busy), 32'd0);
        check32("rst_hi", bus.hi, 32'd0);
        check32("rst_lo", bus.lo, 32'd0);
        reset = 1'b0; bus.start = 1'b0; bus.mdop = 4'd7;
        #1 check32("rst_mfhi", bus.mdout, 32'd0);
        bus.mdop = 4'd0;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // DIV in flight: MFHI sees old hi, MTLO with start is ignored.
        @(negedge clk);
        bus.mdop = 4'd4; bus.a = 32'h64; bus.b = 32'h7; bus.start = 1'b1;
        sb_q.push_back('{32'h2, 32'hE});
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0; bus.a = $urandom; bus.b = $urandom;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            if (n == 2) begin
                bus.mdop = 4'd7; #1 check32("busy_mfhi_old", bus.mdout, 32'h1);
            end
            if (n >= 3 && n <= 5) begin
                bus.mdop = 4'd6; bus.a = 32'hDEADBEEF; bus.start = 1'b1;
            end else begin
                bus.mdop = 4'd0; bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check32("busy_mtlo_cyc", 32'(n), 32'd10);
        check_result("busy_mtlo");

        // Back-to-back MULT: start held through the busy window.
        @(negedge clk);
        bus.mdop = 4'd1; bus.a = 32'h2; bus.b = 32'h3; bus.start = 1'b1;
        sb_q.push_back('{32'h0, 32'h6});
        sb_q.push_back('{32'h0, 32'h14});
        @(negedge clk);
        bus.a = 32'h4; bus.b = 32'h5;
        wait_idle(n);
        check32("b2b_first_cyc", 32'(n), 32'd5);
        check_result("b2b_first");
        bus.mdop = 4'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0; bus.a = $urandom; bus.b = $urandom;
        wait_idle(n);
        check32("b2b_second_cyc", 32'(n), 32'd5);
        check_result("b2b_second");

        // Reset in busy cycle 3 aborts the multiply.
        @(negedge clk);
        bus.mdop = 4'd1; bus.a = 32'h3; bus.b = 32'h5; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.mdop = 4'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check32("abort_busy", 32'(bus.busy), 32'd0);
        check32("abort_hi", bus.hi, 32'd0);
        check32("abort_lo", bus.lo, 32'd0);
        for (int op = 0; op < 16; op++) begin
            bus.mdop = 4'(op);
            #1 check32($sformatf("abort_mdout_op%0d", op), bus.mdout, 32'd0);
        end
        bus.mdop = 4'd0;
        repeat (12) @(negedge clk);
        check32("abort_late_busy", 32'(bus.busy), 32'd0);
        check32("abort_late_hi", bus.hi, 32'd0);
        check32("abort_late_lo", bus.lo, 32'd0);
        check32("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
